// File: rtl/aes128_enc_iter_ctrl_pkg.sv
// Shared AES-128 definitions: FSM encodings, round constants, S-box and
// the SubBytes/ShiftRows byte helpers used by the round controller.
// Byte 0 of every 128-bit word sits in the most significant byte [127:120].
package aes128_enc_iter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aesFsm_e;

  localparam int AES128_NR = 10;
  localparam logic [3:0] LAST_FULL_ROUND = 4'(AES128_NR - 1);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for key-schedule step rnd (1..10); unused codes give zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte index i = 4*col + row; row r is rotated left by r columns.
  function automatic int shiftRowsSrc(input int idx);
    int row;
    int col;
    row = idx % 4;
    col = idx / 4;
    return row + 4 * ((col + row) % 4);
  endfunction

  // SubBytes followed by ShiftRows on a whole state.
  function automatic logic [127:0] subShift(input logic [127:0] st);
    logic [127:0] res;
    int src;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      src = shiftRowsSrc(i);
      res[127 - 8 * i -: 8] = sbox(st[127 - 8 * src -: 8]);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes128_enc_iter_ctrl_key_step.sv
// One on-the-fly AES-128 key-schedule step: round key rnd-1 -> round key rnd.
module aes_key_step
  import aes128_enc_iter_ctrl_pkg::*;
(
  input  logic [127:0] rk_in,
  input  logic [3:0]   rnd,
  output logic [127:0] rk_out
);

  logic [31:0] w_w0;
  logic [31:0] w_w1;
  logic [31:0] w_w2;
  logic [31:0] w_w3;
  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  assign w_w0 = rk_in[127:96];
  assign w_w1 = rk_in[95:64];
  assign w_w2 = rk_in[63:32];
  assign w_w3 = rk_in[31:0];

  assign w_rot = {w_w3[23:0], w_w3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};

  assign w_n0 = w_w0 ^ w_sub ^ {rcon(rnd), 24'h0};
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign rk_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_enc_iter_ctrl_mix_columns.sv
// MixColumns over the full 128-bit state; column c holds bytes 4c..4c+3.
module mixColumns
  import aes128_enc_iter_ctrl_pkg::*;
(
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign o_state[127 - 32 * c -: 32] = mixColumn(i_state[127 - 32 * c -: 32]);
  end

endmodule

// File: rtl/aes128_enc_iter_ctrl.sv
// Iterative AES-128 encryption engine: one round per clock, on-the-fly key
// schedule, valid/ready handshake on both the input and output side.
// Byte 0 of key_in/data_in/data_out is the most significant byte.
module aes128_enc_iter_ctrl
  import aes128_enc_iter_ctrl_pkg::*;
#(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  aesFsm_e      r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_rk;
  logic [3:0]   r_rnd;
  logic [127:0] r_dataOut;
  logic         r_outValid;
  logic         r_inReady;
  logic         r_busy;

  logic [127:0] w_subShift;
  logic [127:0] w_mixed;
  logic [127:0] w_nextKey;
  logic [127:0] w_roundOut;
  logic [127:0] w_finalOut;

  assign w_subShift = subShift(r_state);

  mixColumns u_mixColumns (
    .i_state (w_subShift),
    .o_state (w_mixed)
  );

  aes_key_step u_keyStep (
    .rk_in  (r_rk),
    .rnd    (r_rnd),
    .rk_out (w_nextKey)
  );

  assign w_roundOut = w_mixed ^ w_nextKey;
  assign w_finalOut = w_subShift ^ w_nextKey;

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign data_out  = r_dataOut;
  assign busy      = r_busy;

  // Round FSM: accept, nine full rounds, final round, then hold until drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm      <= ST_IDLE;
      r_state    <= '0;
      r_rk       <= '0;
      r_rnd      <= '0;
      r_dataOut  <= '0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (in_valid && r_inReady) begin
            r_state   <= data_in ^ key_in;
            r_rk      <= key_in;
            r_rnd     <= 4'd1;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_fsm     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_state <= w_roundOut;
          r_rk    <= w_nextKey;
          r_rnd   <= r_rnd + 4'd1;
          if (r_rnd == LAST_FULL_ROUND) begin
            r_fsm <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_state    <= w_finalOut;
          r_rk       <= w_nextKey;
          r_dataOut  <= w_finalOut;
          r_outValid <= 1'b1;
          r_fsm      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
            r_fsm      <= ST_IDLE;
            if (CLEAR_ON_DONE) begin
              r_state <= '0;
              r_rk    <= '0;
            end
          end
        end
        default: begin
          r_fsm      <= ST_IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_iter_ctrl.sv
// Scoreboard bench for the iterative AES-128 engine using FIPS-197 vectors.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_aes128_enc_iter_ctrl;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  int           checks = 0;
  int           errors = 0;
  int           cycleCount = 0;
  logic [127:0] expQ [$];

  aes128_enc_iter_ctrl #(.CLEAR_ON_DONE(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_in    (key_in),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle stamp used to measure the issue interval between accepts.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: every output handshake pops the oldest expected ciphertext.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_unexpected got %h expected no output", data_out);
      end else begin
        checkOutput("scoreboard_data_out", data_out, expQ.pop_front());
      end
    end
  end

  // Present one block and wait for its accept edge; returns at edge+1.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt,
                               input logic [127:0] expCt, input bit track,
                               output int acceptCycle);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout got in_ready=%b expected 1", in_ready);
    end
    key_in   = key;
    data_in  = pt;
    in_valid = 1'b1;
    if (track) expQ.push_back(expCt);
    @(posedge clk);
    #1;
    acceptCycle = cycleCount;
    in_valid    = 1'b0;
  endtask

  // Count falling edges until out_valid appears and compare with expLat.
  task automatic waitValid(input int expLat, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_valid !== 1'b1 && n < 50);
    checks++;
    if (n != expLat || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s got %0d cycles (out_valid=%b) expected %0d", name, n, out_valid, expLat);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc1;
    int acc2;
    int seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    key_in    = '0;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_data_out", data_out, '0);
    @(posedge clk);
    #1;

    $display("[TB] FIPS-197 appendix B");
    applyStimulus(KEY_B, PT_B, CT_B, 1'b1, acc1);
    checkOutput("app_b_busy", busy, 1'b1);
    checkOutput("app_b_in_ready_low", in_ready, 1'b0);
    waitValid(11, "app_b_latency");
    @(negedge clk);
    checkOutput("app_b_pulse", out_valid, 1'b0);
    checkOutput("app_b_in_ready_back", in_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] FIPS-197 appendix C.1");
    applyStimulus(KEY_C, PT_C, CT_C, 1'b1, acc1);
    waitValid(11, "app_c_latency");
    @(negedge clk);
    checkOutput("app_c_pulse", out_valid, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(KEY_B, PT_B, CT_B, 1'b1, acc1);
    waitValid(11, "bp_latency");
    for (int i = 0; i < 20; i++) begin
      checkOutput("bp_data_out", data_out, CT_B);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      checkOutput("bp_out_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_release_in_ready", in_ready, 1'b1);
    checkOutput("bp_release_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] input stability");
    applyStimulus(KEY_B, PT_B, CT_B, 1'b1, acc1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    waitValid(6, "stab_latency");
    @(negedge clk);
    checkOutput("stab_no_second_accept", busy, 1'b0);
    checkOutput("stab_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-operation");
    applyStimulus(KEY_B, PT_B, '0, 1'b0, acc1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_in_ready", in_ready, 1'b1);
    checkOutput("midrst_data_out", data_out, '0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checkOutput("midrst_no_output", 128'(seen), '0);
    @(posedge clk);
    #1;
    applyStimulus(KEY_C, PT_C, CT_C, 1'b1, acc1);
    waitValid(11, "midrst_app_c_latency");
    @(posedge clk);
    #1;

    $display("[TB] back-to-back blocks");
    applyStimulus(KEY_B, PT_B, CT_B, 1'b1, acc1);
    applyStimulus(KEY_C, PT_C, CT_C, 1'b1, acc2);
    checkOutput("b2b_issue_interval", 128'(acc2 - acc1), 128'd12);
    waitValid(11, "b2b_latency");
    @(negedge clk);
    checkOutput("b2b_idle_rk_cleared", dut.r_rk, '0);
    checkOutput("b2b_idle_state_cleared", dut.r_state, '0);
    checkOutput("b2b_data_out_held", data_out, CT_C);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 128'(expQ.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
